// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: write-domain pointer and flag controller for an async FIFO.
// Keeps the binary and Gray write pointers and synchronises the Gray read
// pointer into wclk. From those it derives a registered full flag, fill level
// and almost-full flag, plus a sticky overflow error.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int SYNC_STAGES  = 2,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rptr_gray,
   input  logic                  woverflow_clr,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  woverflow
);

   localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(AFULL_THRESH);

   logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
   logic [ADDR_WIDTH:0] wq_rptr;
   logic [ADDR_WIDTH:0] rbin_sync;
   logic [ADDR_WIDTH:0] wbin;
   logic [ADDR_WIDTH:0] wbin_next;
   logic [ADDR_WIDTH:0] wgray_next;
   logic [ADDR_WIDTH:0] level_next;
   logic [ADDR_WIDTH:0] full_match;

   // Plain flop chain bringing the asynchronous Gray read pointer into wclk
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= rptr_gray;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wq_rptr = sync_q[SYNC_STAGES-1];

   // Gray-to-binary of the synchronised read pointer; bit i is the XOR of bits i and above
   always_comb begin
      rbin_sync = '0;
      for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
         rbin_sync[i] = ^(wq_rptr >> i);
      end
   end

   // Write acceptance and next-pointer terms; wen is also forced low while reset is held
   always_comb begin
      wen        = winc & ~wfull & ~wrst;
      waddr      = wbin[ADDR_WIDTH-1:0];
      wbin_next  = wbin + (ADDR_WIDTH+1)'(wen);
      wgray_next = wbin_next ^ (wbin_next >> 1);
      level_next = wbin_next - rbin_sync;
      full_match = {~wq_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq_rptr[ADDR_WIDTH-2:0]};
   end

   // Pointer, level and flag registers
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         wlevel       <= '0;
         walmost_full <= 1'b0;
         woverflow    <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wptr         <= wgray_next;
         wfull        <= (wgray_next == full_match);
         wlevel       <= level_next;
         walmost_full <= (level_next >= AFULL_LVL);
         woverflow    <= (winc & wfull) | (woverflow & ~woverflow_clr);
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: directed scoreboard bench for fifo_wr_ctrl.
// The stimulus pushes one expected record per checked cycle (at posedge+1).
// The monitor pops and compares on the following negedge.
module tb_fifo_wr_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       wrst = 1'b1;
   logic       winc0 = 1'b0, clr0 = 1'b0;
   logic [3:0] rptr0 = '0;
   logic       wen0, wfull0, waf0, wovf0;
   logic [2:0] waddr0;
   logic [3:0] wptr0, wlvl0;

   logic       winc1 = 1'b0;
   logic [4:0] rptr1 = '0;
   logic       wen1, wfull1, waf1, wovf1;
   logic [3:0] waddr1;
   logic [4:0] wptr1, wlvl1;

   fifo_wr_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AFULL_THRESH(6)) dut0 (
      .wclk(clk), .wrst(wrst), .winc(winc0), .rptr_gray(rptr0), .woverflow_clr(clr0),
      .wen(wen0), .waddr(waddr0), .wptr(wptr0), .wfull(wfull0),
      .walmost_full(waf0), .wlevel(wlvl0), .woverflow(wovf0));

   fifo_wr_ctrl #(.ADDR_WIDTH(4), .SYNC_STAGES(3), .AFULL_THRESH(16)) dut1 (
      .wclk(clk), .wrst(wrst), .winc(winc1), .rptr_gray(rptr1), .woverflow_clr(1'b0),
      .wen(wen1), .waddr(waddr1), .wptr(wptr1), .wfull(wfull1),
      .walmost_full(waf1), .wlevel(wlvl1), .woverflow(wovf1));

   typedef struct {
      int         d;
      string      nm;
      logic       wen;
      logic [3:0] addr;
      logic [4:0] ptr;
      logic       full;
      logic       af;
      logic [4:0] lvl;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_bad = 0;

   function automatic logic [4:0] g(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int d, input string nm, input logic e_wen,
                             input logic [3:0] e_addr, input logic [4:0] e_ptr,
                             input logic e_full, input logic e_af,
                             input logic [4:0] e_lvl, input logic e_ovf);
      exp_t r;
      r.d = d; r.nm = nm; r.wen = e_wen; r.addr = e_addr; r.ptr = e_ptr;
      r.full = e_full; r.af = e_af; r.lvl = e_lvl; r.ovf = e_ovf;
      sb.push_back(r);
   endtask

   task automatic cmp(input string nm, input string f, input logic [4:0] act,
                      input logic [4:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s.%s actual=%0d required=%0d at t=%0t", nm, f, act, req, $time);
      end
   endtask

   // Monitor: pops one record per negedge whenever the stimulus has queued one
   initial begin
      exp_t r;
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            r = sb.pop_front();
            if (r.d == 0) begin
               cmp(r.nm, "wen",   {4'b0, wen0},   {4'b0, r.wen});
               cmp(r.nm, "waddr", {2'b0, waddr0}, {1'b0, r.addr});
               cmp(r.nm, "wptr",  {1'b0, wptr0},  r.ptr);
               cmp(r.nm, "wfull", {4'b0, wfull0}, {4'b0, r.full});
               cmp(r.nm, "wafull",{4'b0, waf0},   {4'b0, r.af});
               cmp(r.nm, "wlevel",{1'b0, wlvl0},  r.lvl);
               cmp(r.nm, "wovf",  {4'b0, wovf0},  {4'b0, r.ovf});
            end else begin
               cmp(r.nm, "wen",   {4'b0, wen1},   {4'b0, r.wen});
               cmp(r.nm, "waddr", {1'b0, waddr1}, {1'b0, r.addr});
               cmp(r.nm, "wptr",  wptr1,          r.ptr);
               cmp(r.nm, "wfull", {4'b0, wfull1}, {4'b0, r.full});
               cmp(r.nm, "wafull",{4'b0, waf1},   {4'b0, r.af});
               cmp(r.nm, "wlevel",wlvl1,          r.lvl);
               cmp(r.nm, "wovf",  {4'b0, wovf1},  {4'b0, r.ovf});
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [4:0] gtab [8] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4};
      logic [3:0] wb, rb, dd, lv;
      logic [3:0] rh [64];
      logic       wi;

      // Reset state, then fill 8 entries with the read pointer at 0
      cyc(); cyc();
      expect_out(0, "reset", 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         wrst = 1'b0; winc0 = 1'b1;
         expect_out(0, "t1_fill", 1, 4'(k), gtab[k], 0, (k >= 6), 5'(k), 0);
      end

      // Overflow and clear behaviour while full
      cyc(); winc0 = 1; clr0 = 0; expect_out(0, "t2_blk0", 0, 0, 12, 1, 1, 8, 0);
      cyc(); winc0 = 1; clr0 = 0; expect_out(0, "t2_blk1", 0, 0, 12, 1, 1, 8, 1);
      cyc(); winc0 = 0; clr0 = 1; expect_out(0, "t2_clr0", 0, 0, 12, 1, 1, 8, 1);
      cyc(); winc0 = 0; clr0 = 0; expect_out(0, "t2_clr1", 0, 0, 12, 1, 1, 8, 0);
      cyc(); winc0 = 1; clr0 = 1; expect_out(0, "t2_pri0", 0, 0, 12, 1, 1, 8, 0);
      cyc(); winc0 = 0; clr0 = 0; expect_out(0, "t2_pri1", 0, 0, 12, 1, 1, 8, 1);
      cyc(); winc0 = 0; clr0 = 1; expect_out(0, "t2_clr2", 0, 0, 12, 1, 1, 8, 1);
      cyc(); winc0 = 0; clr0 = 0; expect_out(0, "t2_clr3", 0, 0, 12, 1, 1, 8, 0);

      // Read release to binary 2: flags hold two edges, update on the third
      cyc(); rptr0 = 4'd3; expect_out(0, "t3_rel0", 0, 0, 12, 1, 1, 8, 0);
      cyc(); expect_out(0, "t3_rel1", 0, 0, 12, 1, 1, 8, 0);
      cyc(); expect_out(0, "t3_rel2", 0, 0, 12, 1, 1, 8, 0);
      cyc(); expect_out(0, "t3_rel3", 0, 0, 12, 0, 1, 6, 0);

      // Lap wrap: read side trails the writer by 4 entries. Level seen at cycle i
      // is wbin(i) minus the read pointer driven three cycles earlier.
      wb = 4'd8; rb = 4'd2;
      rh[0] = 4'd2; rh[1] = 4'd2; rh[2] = 4'd2;
      for (int i = 0; i < 42; i++) begin
         cyc();
         dd = wb - rb;
         if (dd > 4'd4) rb = rb + 4'd1;
         rh[i+3] = rb;
         rptr0 = rb ^ (rb >> 1);
         wi = (i >= 2);
         winc0 = wi;
         lv = wb - rh[i];
         expect_out(0, "t4_lap", wi, {1'b0, wb[2:0]}, g({1'b0, wb}), 0, (lv >= 4'd6),
                    {1'b0, lv}, 0);
         wb = wb + 4'(wi);
      end

      // Async reset, refill to level 5, then reset again between edges
      cyc(); winc0 = 0; rptr0 = 0; wrst = 1;
      expect_out(0, "t5_rst", 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         cyc(); wrst = 0; winc0 = 1;
         expect_out(0, "t5_fill", 1, 4'(k), gtab[k], 0, 0, 5'(k), 0);
      end
      cyc(); winc0 = 0; expect_out(0, "t5_lvl5", 0, 5, 7, 0, 0, 5, 0);
      cyc(); winc0 = 1; #1 wrst = 1;
      expect_out(0, "t5_midrst", 0, 0, 0, 0, 0, 0, 0);
      cyc(); wrst = 0; winc0 = 1; expect_out(0, "t5_first", 1, 0, 0, 0, 0, 0, 0);
      cyc(); winc0 = 0; expect_out(0, "t5_after", 0, 1, 1, 0, 0, 1, 0);

      // Wider instance: 16 deep, 3 sync stages, almost-full at 16
      cyc(); wrst = 1; expect_out(1, "t6_rst", 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 16; k++) begin
         cyc(); wrst = 0; winc1 = 1;
         expect_out(1, "t6_fill", 1, 4'(k), g(5'(k)), 0, 0, 5'(k), 0);
      end
      cyc(); winc1 = 0; rptr1 = 5'd1; expect_out(1, "t6_full", 0, 0, 24, 1, 1, 16, 0);
      for (int k = 0; k < 3; k++) begin
         cyc(); expect_out(1, "t6_hold", 0, 0, 24, 1, 1, 16, 0);
      end
      cyc(); expect_out(1, "t6_rel", 0, 0, 24, 0, 0, 15, 0);

      cyc(); cyc();
      if (sb.size() != 0) begin
         n_vec++; n_bad++;
         $display("FAIL sb_drain actual=%0d required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
Name: fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller for the async FIFO, successor to the fixed-width write-pointer block. Adds:
- depth parametrised by address width
- internal read-pointer synchroniser
- registered fill level and programmable almost-full flag
- sticky overflow error
- write-enable output for the dual-port RAM

Sits between the write-side producer and the FIFO memory. Exports a Gray write pointer to the read domain.

Parameters:
ADDR_WIDTH, 3, RAM address bits; depth DEPTH = 2**ADDR_WIDTH; legal range >= 2
SYNC_STAGES, 2, flop stages on the incoming read pointer; legal range >= 2
AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..DEPTH

Ports:
wclk  in  1  write-domain clock, rising edge
wrst  in  1  reset, asynchronous, active-high
winc  in  1  write request from producer
rptr_gray  in  ADDR_WIDTH+1  Gray read pointer from the read domain (asynchronous to wclk)
woverflow_clr  in  1  clears the woverflow sticky bit
wen  out  1  RAM write enable
waddr  out  ADDR_WIDTH  RAM write address
wptr  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchroniser
wfull  out  1  FIFO full, registered
walmost_full  out  1  wlevel >= AFULL_THRESH, registered
wlevel  out  ADDR_WIDTH+1  fill level as seen by the write domain, 0..DEPTH
woverflow  out  1  sticky: a write was attempted while full

Behaviour:
- Reset (wrst=1, asynchronous): all state clears immediately, independent of wclk.
  - Cleared: the sync chain, wbin, wptr, wfull, walmost_full, wlevel, woverflow.
  - Consequently waddr=0 and wen=0 during reset.
  - Reset mid-burst discards all in-flight state; the first post-reset write goes to address 0.
- Synchroniser: rptr_gray passes through SYNC_STAGES flops. wq_rptr is the last stage. No logic between stages.
- rbin_sync: Gray-to-binary conversion of wq_rptr (combinational).
- Accept: wen = winc & ~wfull (combinational). waddr = wbin[ADDR_WIDTH-1:0], the binary pointer register.
- Next-state terms:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1). This is the natural wrap; the extra MSB is the lap bit.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- Per wclk edge:
  - wbin <= wbin_next
  - wptr <= wgray_next
  - wfull <= (wgray_next == {~wq_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq_rptr[ADDR_WIDTH-2:0]})
  - wlevel <= (wbin_next - rbin_sync), modulo 2**(ADDR_WIDTH+1)
  - walmost_full <= (wbin_next - rbin_sync) >= AFULL_THRESH
  - woverflow <= (winc & wfull) | (woverflow & ~woverflow_clr)
- woverflow: set has priority over a simultaneous clear.
- Write-side latency: wfull asserts on the same edge that accepts the DEPTH-th unread write. wen is therefore 0 on the next cycle.
- Read-release latency: a change on rptr_gray reaches wq_rptr after SYNC_STAGES edges. wfull, wlevel and walmost_full reflect it on the following edge, i.e. SYNC_STAGES+1 edges after the change.
- Conservatism: wlevel can only over-estimate the true occupancy, never under-estimate it. wfull can deassert late but never early.
- Blocked write: a write attempted while wfull=1 is dropped. wbin, wptr and waddr are unchanged.
- Simultaneous write and read release: both apply; the level is computed from wbin_next and the current wq_rptr.
- rptr_gray must change by at most one Gray step per read-clock edge. This is the read domain's responsibility; it is not checked here.

Test Plan:
1. Reset then fill, defaults, rptr_gray=0, winc=1 for 8 cycles.
   -> waddr 0..7; wptr 0,1,3,2,6,7,5,4 then 12; wfull=1 after 8th edge; wlevel=8; walmost_full=1 from the edge where wlevel=6.
2. Overflow, full, winc=1 for 2 cycles.
   -> wen=0; waddr stays 0; wptr stays 12; woverflow=1. Pulse woverflow_clr with winc=0 -> woverflow=0. Clear and winc=1 together -> woverflow stays 1.
3. Read release, full, set rptr_gray=3 (binary 2).
   -> wfull, wlevel and walmost_full hold for 2 edges; on 3rd edge wfull=0, wlevel=6, walmost_full=1.
4. Lap wrap: 40 writes with rptr_gray tracking the write pointer 4 entries behind, via a bench model of the read side.
   -> wbin wraps at 16 with no spurious wfull; wlevel settles to 4 plus synchroniser lag and never exceeds 8.
5. Mid-burst async reset: assert wrst between clock edges while wlevel=5.
   -> all outputs 0 before the next edge; first write after release uses waddr=0, wptr becomes 1.
6. Parameter sweep ADDR_WIDTH=4, SYNC_STAGES=3, AFULL_THRESH=16.
   -> wfull after 16 writes; walmost_full and wfull assert on the same edge; release latency is 4 edges.
